// File: rtl/booth_mult_radix4.sv
// Sequential 32x32 signed multiplier using radix-4 Booth recoding.
// A start strobe loads the operands; 16 iterations later a one-cycle ready strobe presents the low word and an overflow flag.
module booth_mult_radix4 (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic [33:0] acc;
    logic [31:0] mplier;
    logic        q_m1;
    logic [31:0] mcand;

    logic [33:0] m_ext;
    logic [33:0] term;
    logic [33:0] acc_sum;
    logic [33:0] acc_next;
    logic [31:0] mplier_next;
    logic        ovf_next;

    // One Booth step: pick 0/+-M/+-2M, add, then arithmetic shift the whole {acc, mplier, q_m1} right by two.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        term  = '0;
        m_ext = {{2{mcand[31]}}, mcand};
        case ({mplier[1:0], q_m1})
            3'b001, 3'b010: term = m_ext;
            3'b011:         term = m_ext << 1;
            3'b100:         term = -(m_ext << 1);
            3'b101, 3'b110: term = -m_ext;
            default:        term = '0;
        endcase
        acc_sum     = acc + term;
        acc_next    = {{2{acc_sum[33]}}, acc_sum[33:2]};
        mplier_next = {acc_sum[1:0], mplier[31:2]};
        ovf_next    = (acc_next[31:0] != {32{mplier_next[31]}});
    end

    // NOTE: all state here is sequential and uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            acc            <= '0;
            mplier         <= '0;
            q_m1           <= 1'b0;
            mcand          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT && (state == IDLE || state == RUN || state == DONE)) begin
                // A start in any state (including mid-run) reloads and restarts; an aborted run never strobes.
                mcand  <= data_operandA;
                mplier <= data_operandB;
                acc    <= '0;
                q_m1   <= 1'b0;
                count  <= '0;
                state  <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        acc    <= acc_next;
                        mplier <= mplier_next;
                        q_m1   <= mplier[1];
                        if (count == 4'd15) begin
                            state          <= DONE;
                            data_result    <= mplier_next;
                            data_exception <= ovf_next;
                            data_resultRDY <= 1'b1;
                        end else begin
                            count <= count + 4'd1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
